// File: rtl/arb_pkg.sv
// Shared definitions for the N-way arbiter: FSM state encoding and width helper.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2s(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational circular priority picker: first set candidate at or after start, wrapping.
module arb_pick
  import arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = clog2s(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  win_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  logic [N-1:0]  rot;
  logic [IW-1:0] rot_idx;

  // (a + b) mod N, valid because both operands are below N.
  function automatic logic [IW-1:0] wrap(input int unsigned a, input logic [IW-1:0] b);
    int unsigned s;
    s = a + 32'(b);
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Rotate so that position 0 corresponds to start.
  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rot[i] = cand[wrap(i, start)];
    end
  end

  // Lowest set bit of the rotated vector.
  always_comb begin
    any_c   = 1'b0;
    rot_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_c && rot[i]) begin
        any_c   = 1'b1;
        rot_idx = IW'(i);
      end
    end
  end

  // Un-rotate back to the requester index.
  always_comb begin
    idx_c = wrap(32'(rot_idx), start);
    win_c = any_c ? (N'(1) << idx_c) : '0;
  end

endmodule

// File: rtl/arb_rr_n.sv
// N-way arbiter with registered one-hot grant, fixed or round-robin priority,
// zero-bubble handover and optional maximum-hold preemption.
module arb_rr_n
  import arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned RR      = 1,
  parameter int unsigned MAXHOLD = 0
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic [N-1:0]          r,
  output logic [N-1:0]          g,
  output logic [clog2s(N)-1:0]  gid,
  output logic                  busy
);

  localparam int unsigned IW = clog2s(N);
  localparam int unsigned CW = clog2s(MAXHOLD + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAXHOLD);

  state_t        st, st_d;
  logic [N-1:0]  g_d;
  logic [IW-1:0] gid_d;
  logic          busy_d;
  logic [IW-1:0] last, last_d;
  logic [CW-1:0] cnt, cnt_d;

  logic [N-1:0]  cand;
  logic [IW-1:0] start;
  logic [N-1:0]  win_c;
  logic [IW-1:0] idx_c;
  logic          any_c;
  logic          own_req;
  logic          preempt;

  // The owner is never its own candidate, so handover and preemption skip it.
  assign cand    = r & ~g;
  assign own_req = |(r & g);
  assign start   = (RR == 0) ? '0 :
                   (last == IW'(N - 1)) ? '0 : last + IW'(1);
  assign preempt = (MAXHOLD != 0) && (cnt == MAXC) && any_c;

  arb_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .cand  (cand),
    .start (start),
    .win_c (win_c),
    .idx_c (idx_c),
    .any_c (any_c)
  );

  // State and output registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      st   <= ST_IDLE;
      g    <= '0;
      gid  <= '0;
      busy <= 1'b0;
      last <= IW'(N - 1);
      cnt  <= '0;
    end else begin
      st   <= st_d;
      g    <= g_d;
      gid  <= gid_d;
      busy <= busy_d;
      last <= last_d;
      cnt  <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    st_d = st;
    case (st)
      ST_IDLE:  if (|r) st_d = ST_GRANT;
      ST_GRANT: if (!own_req && !any_c) st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  // Next grant, pointer and hold counter.
  always_comb begin
    g_d    = g;
    gid_d  = gid;
    last_d = last;
    cnt_d  = cnt;
    case (st)
      ST_IDLE: begin
        if (any_c) begin
          g_d    = win_c;
          gid_d  = idx_c;
          last_d = idx_c;
          cnt_d  = CW'(1);
        end
      end
      ST_GRANT: begin
        if (own_req && !preempt) begin
          if (cnt < MAXC) cnt_d = cnt + CW'(1);
        end else if (any_c) begin
          g_d    = win_c;
          gid_d  = idx_c;
          last_d = idx_c;
          cnt_d  = CW'(1);
        end else begin
          g_d = '0;
        end
      end
      default: g_d = '0;
    endcase
    busy_d = |g_d;
  end

endmodule

// File: tb/tb_arb_rr_n.sv
// Bench for arb_rr_n: four N=4 configurations driven side by side against a behavioural model.
module tb_arb_rr_n;

  logic       Clock;
  logic       Resetn;
  logic [3:0] rq   [4];
  logic [3:0] gq   [4];
  logic [1:0] gidq [4];
  logic       bq   [4];

  int tests;
  int fails;

  // Model state per instance: owner (-1 idle), last grant, hold count.
  int m_own  [4];
  int m_last [4];
  int m_cnt  [4];

  // Instance k configuration: 0 RR, 1 fixed, 2 RR+MAXHOLD=2, 3 fixed+MAXHOLD=2.
  arb_rr_n #(.N(4), .RR(1), .MAXHOLD(0)) u_rr (
    .Clock(Clock), .Resetn(Resetn), .r(rq[0]), .g(gq[0]), .gid(gidq[0]), .busy(bq[0]));
  arb_rr_n #(.N(4), .RR(0), .MAXHOLD(0)) u_fx (
    .Clock(Clock), .Resetn(Resetn), .r(rq[1]), .g(gq[1]), .gid(gidq[1]), .busy(bq[1]));
  arb_rr_n #(.N(4), .RR(1), .MAXHOLD(2)) u_rrmh (
    .Clock(Clock), .Resetn(Resetn), .r(rq[2]), .g(gq[2]), .gid(gidq[2]), .busy(bq[2]));
  arb_rr_n #(.N(4), .RR(0), .MAXHOLD(2)) u_fxmh (
    .Clock(Clock), .Resetn(Resetn), .r(rq[3]), .g(gq[3]), .gid(gidq[3]), .busy(bq[3]));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic bit cfg_rr(input int k);
    return (k == 0) || (k == 2);
  endfunction

  function automatic int cfg_mh(input int k);
    return (k >= 2) ? 2 : 0;
  endfunction

  function automatic int pick(input int k, input logic [3:0] c);
    if (cfg_rr(k)) begin
      for (int d = 1; d <= 4; d++) begin
        if (c[(m_last[k] + d) % 4]) return (m_last[k] + d) % 4;
      end
    end else begin
      for (int i = 0; i < 4; i++) if (c[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_own[k]  = -1;
      m_last[k] = 3;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] rv);
    logic [3:0] oth;
    int p;
    int mh;
    mh = cfg_mh(k);
    p  = -1;
    if (m_own[k] < 0) begin
      if (rv != 0) p = pick(k, rv);
    end else begin
      oth = rv;
      oth[m_own[k]] = 1'b0;
      if (rv[m_own[k]] && !(mh > 0 && m_cnt[k] >= mh && oth != 0)) begin
        if (mh > 0 && m_cnt[k] < mh) m_cnt[k]++;
      end else if (oth != 0) begin
        p = pick(k, oth);
      end else begin
        m_own[k] = -1;
      end
    end
    if (p >= 0) begin
      m_own[k]  = p;
      m_last[k] = p;
      m_cnt[k]  = 1;
    end
  endtask

  // One clock: model follows the r values the DUTs sample, outputs settle #1 later.
  task automatic tick();
    @(posedge Clock);
    for (int k = 0; k < 4; k++) model_step(k, rq[k]);
    #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    for (int k = 0; k < 4; k++) rq[k] = '0;
    model_reset();
    @(posedge Clock);
    @(posedge Clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (gq[k] !== 4'b0 || gidq[k] !== 2'd0 || bq[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset inst%0d: g=%b gid=%0d busy=%b required g=0000 gid=0 busy=0",
                 k, gq[k], gidq[k], bq[k]);
      end
    end
    Resetn = 1'b1;
  endtask

  task automatic test_rr_rotation();
    int own;
    rq[0] = 4'b1111;
    tick();
    for (int s = 0; s < 5; s++) begin
      own = s % 4;
      for (int c = 0; c < 3; c++) begin
        if (c > 0) tick();
        tests++;
        if (gq[0] !== (4'b0001 << own) || gidq[0] !== 2'(own) || bq[0] !== 1'b1) begin
          fails++;
          $display("FAIL rr_rotation s=%0d c=%0d: g=%b gid=%0d busy=%b required g=%b gid=%0d busy=1",
                   s, c, gq[0], gidq[0], bq[0], 4'b0001 << own, own);
        end
      end
      rq[0][own] = 1'b0;
      tick();
      rq[0][own] = 1'b1;
    end
    rq[0] = '0;
    tick();
    tests++;
    if (gq[0] !== 4'b0 || bq[0] !== 1'b0) begin
      fails++;
      $display("FAIL rr_release: g=%b busy=%b required g=0000 busy=0", gq[0], bq[0]);
    end
  endtask

  task automatic test_fixed_priority();
    rq[1] = 4'b1010;
    tick();
    tests++;
    if (gq[1] !== 4'b0010 || gidq[1] !== 2'd1) begin
      fails++;
      $display("FAIL fixed_first: g=%b gid=%0d required g=0010 gid=1", gq[1], gidq[1]);
    end
    rq[1] = 4'b1000;
    tick();
    tests++;
    if (gq[1] !== 4'b1000 || gidq[1] !== 2'd3) begin
      fails++;
      $display("FAIL fixed_handover: g=%b gid=%0d required g=1000 gid=3", gq[1], gidq[1]);
    end
    rq[1] = '0;
    tick();
  endtask

  task automatic test_maxhold_preempt();
    logic [3:0] exp_seq [8];
    exp_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    rq[2] = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (gq[2] !== exp_seq[i]) begin
        fails++;
        $display("FAIL maxhold_preempt cycle %0d: g=%b required %b", i, gq[2], exp_seq[i]);
      end
    end
    rq[2] = '0;
    tick();
  endtask

  task automatic test_maxhold_alone();
    rq[2] = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (gq[2] !== 4'b0100 || gidq[2] !== 2'd2) begin
        fails++;
        $display("FAIL maxhold_alone cycle %0d: g=%b gid=%0d required g=0100 gid=2",
                 i, gq[2], gidq[2]);
      end
    end
    rq[2] = '0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    rq[0] = 4'b1000;
    tick();
    tests++;
    if (gq[0] !== 4'b1000) begin
      fails++;
      $display("FAIL pre_reset_grant: g=%b required 1000", gq[0]);
    end
    #2 Resetn = 1'b0;
    #1;
    tests++;
    if (gq[0] !== 4'b0 || bq[0] !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_clear: g=%b busy=%b required g=0000 busy=0", gq[0], bq[0]);
    end
    #2 Resetn = 1'b1;
    model_reset();
    tick();
    tests++;
    if (gq[0] !== 4'b1000 || gidq[0] !== 2'd3) begin
      fails++;
      $display("FAIL post_reset_grant: g=%b gid=%0d required g=1000 gid=3", gq[0], gidq[0]);
    end
    // Move the pointer to 1, reset, and confirm the round-robin search restarts at 0.
    rq[0] = 4'b0010;
    tick();
    #2 Resetn = 1'b0;
    #2 Resetn = 1'b1;
    model_reset();
    rq[0] = 4'b1010;
    tick();
    tests++;
    if (gq[0] !== 4'b0010 || gidq[0] !== 2'd1) begin
      fails++;
      $display("FAIL pointer_restart: g=%b gid=%0d required g=0010 gid=1", gq[0], gidq[0]);
    end
    rq[0] = '0;
    tick();
  endtask

  task automatic test_idle_then_req();
    rq[0] = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (bq[0] !== 1'b0 || !$onehot0(gq[0])) begin
        fails++;
        $display("FAIL idle_busy cycle %0d: busy=%b g=%b required busy=0 g=0000", i, bq[0], gq[0]);
      end
    end
    rq[0] = 4'b0001;
    tick();
    tests++;
    if (bq[0] !== 1'b1 || gidq[0] !== 2'd0 || gq[0] !== 4'b0001) begin
      fails++;
      $display("FAIL idle_to_grant: busy=%b gid=%0d g=%b required busy=1 gid=0 g=0001",
               bq[0], gidq[0], gq[0]);
    end
    rq[0] = '0;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] exp_g;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 7))
          0:       rq[k] = 4'($urandom);
          1, 2:    rq[k] = rq[k] ^ (4'b0001 << $urandom_range(0, 3));
          3:       if ($urandom_range(0, 3) == 0) rq[k] = '0;
          default: ;
        endcase
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        exp_g = (m_own[k] < 0) ? 4'b0 : (4'b0001 << m_own[k]);
        tests++;
        if (gq[k] !== exp_g || bq[k] !== (m_own[k] >= 0) || !$onehot0(gq[k]) ||
            (m_own[k] >= 0 && gidq[k] !== 2'(m_own[k]))) begin
          fails++;
          $display("FAIL random inst%0d cycle %0d: g=%b gid=%0d busy=%b required g=%b gid=%0d busy=%b",
                   k, cyc, gq[k], gidq[k], bq[k], exp_g, m_own[k], m_own[k] >= 0);
        end
      end
    end
    for (int k = 0; k < 4; k++) rq[k] = '0;
    tick();
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    Resetn = 1'b0;
    test_reset();
    test_rr_rotation();
    test_fixed_priority();
    test_maxhold_preempt();
    test_maxhold_alone();
    test_reset_mid_grant();
    test_idle_then_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arb_rr_n.md
# arb_rr_n

Parametrised N-way arbiter with registered one-hot grants. It is the successor to the 3-way fixed-priority grant FSM and sits in front of any shared resource (bus, memory port, or serialiser). It adds:
- selectable fixed-priority or round-robin mode
- grant handover without an idle cycle
- an optional maximum-hold preemption limit
- an encoded grant index

## Interface
Parameters:
- N, default 4: number of requesters; range 2..32.
- RR, default 1: 1 selects round-robin, 0 selects fixed priority (index 0 highest).
- MAXHOLD, default 0: maximum consecutive grant cycles while another requester waits; 0 means unlimited.

Ports:
- Clock  input  1  sole clock; all state updates on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- r  input  N  request vector; r[i] is held high for as long as requester i needs the resource.
- g  output  N  registered one-hot grant; all zeros when idle.
- gid  output  $clog2(N)  index of the granted requester; valid only while busy is high.
- busy  output  1  high when any grant is asserted; equals |g.

## Operation
State machine, two states:
- IDLE: g = 0.
  - If r = 0, stay in IDLE.
  - Otherwise move to GRANT with the winner chosen by the pick function.
- GRANT: owner is gid.
  - If r[gid] = 1 and no preemption is due, hold the grant.
  - If r[gid] = 0 and other requests are pending, hand over directly to the pick winner. No idle cycle is inserted.
  - If r[gid] = 0 and nothing else is pending, return to IDLE.

Pick function:
- Fixed mode: lowest set index of the candidate vector.
- RR mode: first set index searching upward from last+1, wrapping from N-1 to 0.
- `last` is the index of the most recent grant. It is updated on every new grant.
- During handover, the current owner is excluded from the candidate vector.

Preemption (MAXHOLD > 0):
- Hold counter `cnt` is loaded with 1 on every new grant and increments each GRANT cycle.
- `cnt` saturates at MAXHOLD.
- If cnt = MAXHOLD and any other request is pending, the grant passes to the pick winner on the next edge, even though r[owner] is still 1.
- In RR mode the former owner becomes lowest priority. In fixed mode it is excluded for that one pick only.
- If no other request is pending, the owner keeps the grant and cnt stays saturated.

Grant rules:
- A requester whose r drops loses g on the next edge.
- An r pulse that starts and ends between edges is not seen.

Reset values:
- g = 0, gid = 0, busy = 0, state = IDLE, cnt = 0.
- last = N-1, so the first round-robin pick starts at index 0.
- Assertion of Resetn mid-grant clears g immediately (asynchronously). Arbitration restarts on the first edge after release.

## Timing
- Request-to-grant latency: 1 cycle. r is sampled at edge k and g is valid after edge k.
- Release-to-regrant latency: 1 cycle. g moves from the old owner to the new one on the same edge, so g is never 2-hot.
- Simultaneous events: release and new requests in the same cycle resolve as a handover. The requests are resolved by the pick function.
- gid, busy and g always change on the same edge.

## Structure
Package arb_pkg contains:
- state encoding constants ST_IDLE and ST_GRANT
- the function clog2s(n), which returns a minimum width of 1

Sub-module arb_pick (combinational):
- Inputs: candidate vector and start index.
- Outputs: one-hot winner plus index, using a rotate, priority-encode, un-rotate scheme.
- Fixed mode instantiates it with start = 0.

The top level holds the FSM, `last`, `cnt` and the output registers.

## Test plan
All scenarios use N = 4.
- RR=1, MAXHOLD=0, r=4'b1111 from reset, with each owner dropping its r for 1 cycle after holding 3 cycles -> grants 0,1,2,3,0 in order, with no idle cycle between them. The dropping owner re-asserts after that cycle and stays queued.
- RR=0, r=4'b1010 -> g=4'b0010 and gid=1 one cycle later. Then drop r[1] -> g=4'b1000 on the next edge.
- RR=1, MAXHOLD=2, r=4'b0011 held constant -> g alternates 0001, 0001, 0010, 0010, 0001, and so on.
- MAXHOLD=2, r=4'b0100 alone for 10 cycles -> g=4'b0100 throughout, with no preemption.
- Resetn pulsed low mid-grant with r=4'b1000 -> g=0 without waiting for a Clock edge. After release, g=4'b1000 one cycle later and last restarts the round-robin pointer from 0.
- r=0 held for 5 cycles, then r=4'b0001 -> busy=0 through idle, then busy=1 and gid=0 after 1 cycle. Check on every cycle that g is one-hot or zero.
